// File: rtl/dispgen_pkg.sv
// rtl/dispgen_pkg.sv - shared phase encoding, count width and 640x480 timing defaults
package dispgen_pkg;

  localparam int COUNT_W   = 12;
  localparam int COUNT_MAX = (1 << COUNT_W) - 1;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  // Boundaries are exclusive upper limits of ACTIVE, FRONT and SYNC.
  function automatic phase_t phase_of(input logic [COUNT_W-1:0] n,
                                      input logic [COUNT_W-1:0] act_end,
                                      input logic [COUNT_W-1:0] front_end,
                                      input logic [COUNT_W-1:0] sync_end);
    phase_t ph;
    if (n < act_end)        ph = PH_ACTIVE;
    else if (n < front_end) ph = PH_FRONT;
    else if (n < sync_end)  ph = PH_SYNC;
    else                    ph = PH_BACK;
    return ph;
  endfunction

endpackage

// File: rtl/dispsync_axis.sv
// rtl/dispsync_axis.sv - one timing axis: wrapping counter with registered phase decode
module dispsync_axis
  import dispgen_pkg::*;
#(
  parameter int ACT  = DEF_H_ACT,
  parameter int FP   = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               step,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output phase_t             phase,
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] LAST      = COUNT_W'(ACT + FP + SYNC + BP - 1);
  localparam logic [COUNT_W-1:0] ACT_END   = COUNT_W'(ACT);
  localparam logic [COUNT_W-1:0] FRONT_END = COUNT_W'(ACT + FP);
  localparam logic [COUNT_W-1:0] SYNC_END  = COUNT_W'(ACT + FP + SYNC);

  logic [COUNT_W-1:0] count_nxt;

  assign wrap      = (count == LAST);
  assign count_nxt = wrap ? '0 : count + 1'b1;

  // Phase is decoded from the next count so it lands on the same edge as the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else if (clear) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else if (step) begin
      count <= count_nxt;
      phase <= phase_of(count_nxt, ACT_END, FRONT_END, SYNC_END);
    end
  end

endmodule

// File: rtl/dispsync.sv
// rtl/dispsync.sv - video timing sequencer: pixel enable, H/V counters, sync and DE strobes
module dispsync
  import dispgen_pkg::*;
#(
  parameter int   CKE_DIV = 2,
  parameter int   H_ACT   = DEF_H_ACT,
  parameter int   H_FP    = DEF_H_FP,
  parameter int   H_SYNC  = DEF_H_SYNC,
  parameter int   H_BP    = DEF_H_BP,
  parameter int   V_ACT   = DEF_V_ACT,
  parameter int   V_FP    = DEF_V_FP,
  parameter int   V_SYNC  = DEF_V_SYNC,
  parameter int   V_BP    = DEF_V_BP,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ENABLE,
  output logic               TX_CLK,
  output logic               TX_HS,
  output logic               TX_VS,
  output logic               TX_DE,
  output logic [COUNT_W-1:0] H_COUNT,
  output logic [COUNT_W-1:0] V_COUNT,
  output logic               FRAME_START,
  output logic               BUSY
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  if (CKE_DIV < 1 || CKE_DIV > 15 ||
      H_ACT < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACT < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > COUNT_MAX || V_TOTAL > COUNT_MAX) begin : g_bad_params
    $error("dispsync: timing parameters out of range");
  end

  localparam logic [3:0] DIV_LAST = 4'(CKE_DIV - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t     state;
  logic [3:0] div_cnt;
  logic       run;
  logic       h_wrap;
  logic       v_wrap;
  phase_t     h_phase;
  phase_t     v_phase;

  assign run = (state == ST_RUN);

  // Divider keeps running in IDLE so downstream pipelines still see pixel enables.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= 4'd0;
      TX_CLK  <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      TX_CLK  <= (div_cnt == DIV_LAST);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= 1'b0;
      if (TX_CLK) begin
        if (!run) begin
          if (ENABLE) begin
            state       <= ST_RUN;
            FRAME_START <= 1'b1;
          end
        end else if (h_wrap && v_wrap) begin
          if (ENABLE) FRAME_START <= 1'b1;
          else        state       <= ST_IDLE;
        end
      end
    end
  end

  dispsync_axis #(
    .ACT  (H_ACT),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP)
  ) u_h_axis (
    .CLK   (CLK),
    .RST_N (RST_N),
    .step  (TX_CLK & run),
    .clear (TX_CLK & ~run),
    .count (H_COUNT),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  dispsync_axis #(
    .ACT  (V_ACT),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP)
  ) u_v_axis (
    .CLK   (CLK),
    .RST_N (RST_N),
    .step  (TX_CLK & run & h_wrap),
    .clear (TX_CLK & ~run),
    .count (V_COUNT),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  assign BUSY  = run;
  assign TX_DE = run && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign TX_HS = (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
  assign TX_VS = (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_dispsync.sv
// tb/tb_dispsync.sv - vector table and frame-start scoreboard bench for dispsync
module tb_dispsync;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n, enable;
  logic        tx_clk, tx_hs, tx_vs, tx_de, frame_start, busy;
  logic [11:0] h_count, v_count;

  logic        rst_f, en_f;
  logic        tx_clk_f, tx_hs_f, tx_vs_f, tx_de_f, frame_start_f, busy_f;
  logic [11:0] h_count_f, v_count_f;

  dispsync #(
    .CKE_DIV(2), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .CLK(CLK), .RST_N(rst_n), .ENABLE(enable),
    .TX_CLK(tx_clk), .TX_HS(tx_hs), .TX_VS(tx_vs), .TX_DE(tx_de),
    .H_COUNT(h_count), .V_COUNT(v_count),
    .FRAME_START(frame_start), .BUSY(busy)
  );

  dispsync #(
    .CKE_DIV(1), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_f (
    .CLK(CLK), .RST_N(rst_f), .ENABLE(en_f),
    .TX_CLK(tx_clk_f), .TX_HS(tx_hs_f), .TX_VS(tx_vs_f), .TX_DE(tx_de_f),
    .H_COUNT(h_count_f), .V_COUNT(v_count_f),
    .FRAME_START(frame_start_f), .BUSY(busy_f)
  );

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] h;
    logic       de;
    logic       hs;
    logic       vs;
    logic       en;
  } vec_t;

  vec_t vecs [16];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   cyc_f = 0;
  int   fs_q [$];

  always @(posedge CLK) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
    if (!rst_f) cyc_f <= 0;
    else        cyc_f <= cyc_f + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic goto_f(input int k);
    while (cyc_f < k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Frame starts are checked against the CLK index at which they were predicted.
  always @(negedge CLK) begin
    if (frame_start) begin
      if (fs_q.size() == 0) chk("frame_start unexpected", cyc, -1);
      else                  chk("frame_start cycle", cyc, fs_q.pop_front());
    end
  end

  task automatic check_reset_levels(input string tag);
    chk({tag, " tx_clk"}, tx_clk, 0);
    chk({tag, " tx_hs"}, tx_hs, 1);
    chk({tag, " tx_vs"}, tx_vs, 1);
    chk({tag, " tx_de"}, tx_de, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_start"}, frame_start, 0);
    chk({tag, " h_count"}, h_count, 0);
    chk({tag, " v_count"}, v_count, 0);
  endtask

  task automatic main_seq();
    int h, v, p, de_n, vs_n;
    vecs = '{
      '{4'd0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1},
      '{4'd0, 4'd7,  1'b1, 1'b1, 1'b1, 1'b1},
      '{4'd0, 4'd8,  1'b0, 1'b1, 1'b1, 1'b1},
      '{4'd0, 4'd9,  1'b0, 1'b1, 1'b1, 1'b1},
      '{4'd0, 4'd10, 1'b0, 1'b0, 1'b1, 1'b1},
      '{4'd0, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1},
      '{4'd0, 4'd13, 1'b0, 1'b1, 1'b1, 1'b1},
      '{4'd1, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0},
      '{4'd3, 4'd7,  1'b1, 1'b1, 1'b1, 1'b0},
      '{4'd4, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0},
      '{4'd4, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0},
      '{4'd5, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0},
      '{4'd5, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'd6, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0},
      '{4'd7, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0},
      '{4'd7, 4'd13, 1'b0, 1'b1, 1'b1, 1'b0}
    };
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_levels("in reset");
    rst_n = 1'b1;

    for (int k = 1; k <= 10; k++) begin
      goto(k);
      chk($sformatf("idle tx_clk k=%0d", k), tx_clk, int'(k % 2 == 0));
      chk($sformatf("idle de k=%0d", k), tx_de, 0);
      chk($sformatf("idle busy k=%0d", k), busy, 0);
      chk($sformatf("idle hs/vs k=%0d", k), {tx_hs, tx_vs}, 3);
    end

    // Raised after edge 10 (TX_CLK high) -> loads (0,0) at edge 11; next frame 224 CLK later.
    enable = 1'b1;
    fs_q.push_back(11);
    fs_q.push_back(235);
    de_n = 0;
    vs_n = 0;
    for (int q = 0; q < 112; q++) begin
      goto(11 + 2 * q);
      h = q % 14;
      v = q / 14;
      chk($sformatf("f1 h p=%0d", q), h_count, h);
      chk($sformatf("f1 v p=%0d", q), v_count, v);
      chk($sformatf("f1 de p=%0d", q), tx_de, int'(h < 8 && v < 4));
      chk($sformatf("f1 hs p=%0d", q), tx_hs, int'(!(h >= 10 && h <= 12)));
      chk($sformatf("f1 vs p=%0d", q), tx_vs, int'(!(v >= 5 && v <= 6)));
      chk($sformatf("f1 busy p=%0d", q), busy, 1);
      if (tx_de) de_n++;
      if (!tx_vs) vs_n++;
    end
    chk("f1 de step count", de_n, 32);
    chk("f1 vs low step count", vs_n, 28);

    for (int i = 0; i < 16; i++) begin
      p = int'(vecs[i].v) * 14 + int'(vecs[i].h);
      goto(235 + 2 * p);
      chk($sformatf("vec%0d h", i), h_count, vecs[i].h);
      chk($sformatf("vec%0d v", i), v_count, vecs[i].v);
      chk($sformatf("vec%0d de", i), tx_de, vecs[i].de);
      chk($sformatf("vec%0d hs", i), tx_hs, vecs[i].hs);
      chk($sformatf("vec%0d vs", i), tx_vs, vecs[i].vs);
      chk($sformatf("vec%0d busy", i), busy, 1);
      enable = vecs[i].en;
    end

    goto(459);
    chk("stop busy", busy, 0);
    chk("stop h", h_count, 0);
    chk("stop v", v_count, 0);
    chk("stop de", tx_de, 0);
    chk("stop hs/vs", {tx_hs, tx_vs}, 3);

    // Pulse that covers no step edge must be ignored.
    goto(461);
    enable = 1'b1;
    goto(462);
    enable = 1'b0;
    for (int k = 463; k <= 470; k++) begin
      goto(k);
      chk($sformatf("short pulse busy k=%0d", k), busy, 0);
    end

    enable = 1'b1;
    fs_q.push_back(471);
    goto(471);
    chk("restart h", h_count, 0);
    chk("restart v", v_count, 0);
    chk("restart de", tx_de, 1);
    chk("restart busy", busy, 1);

    goto(537);
    chk("pre-reset h", h_count, 5);
    chk("pre-reset v", v_count, 2);
    chk("pre-reset de", tx_de, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_levels("async reset");
    repeat (2) @(posedge CLK);
    #1;
    rst_n = 1'b1;
    fs_q.push_back(3);
    goto(2);
    chk("post-reset busy k=2", busy, 0);
    chk("post-reset tx_clk k=2", tx_clk, 1);
    goto(3);
    chk("post-reset h", h_count, 0);
    chk("post-reset v", v_count, 0);
    chk("post-reset de", tx_de, 1);
    chk("post-reset busy", busy, 1);
    goto(12);
    chk("frame_start queue drained", fs_q.size(), 0);
  endtask

  task automatic fast_seq();
    rst_f = 1'b0;
    en_f  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("div1 reset tx_clk", tx_clk_f, 0);
    chk("div1 reset busy", busy_f, 0);
    rst_f = 1'b1;
    for (int k = 1; k <= 230; k++) begin
      goto_f(k);
      chk($sformatf("div1 tx_clk k=%0d", k), tx_clk_f, 1);
      chk($sformatf("div1 frame_start k=%0d", k), frame_start_f,
          int'(k == 2 || k == 114 || k == 226));
      if (k == 2) begin
        chk("div1 first de", tx_de_f, 1);
        chk("div1 first h", h_count_f, 0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      main_seq();
      fast_seq();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
